seg_static_src: RTL and testbench

- Upstream source for the 74HC595 serial shifter.
- Generates the segment pattern (seg) and digit-enable vector (sel) for static six-digit display: all digits show the same hex value, advancing 0..F on a fixed time base.
- Drives the shifter's parallel seg/sel inputs directly.
- Provides an update strobe so downstream or debug logic can see when a new pattern is valid.

---
 rtl/seg_pkg.sv | 15 +
 rtl/seg_hex_enc.sv | 14 +
 rtl/seg_static_src.sv | 81 ++++++++
 tb/tb_seg_static_src.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions for the static and dynamic-scan display sources.
package seg_pkg;

  typedef logic [3:0] hex_t;

  // Common-anode, active-low patterns. Bit 7 is the decimal point and is held off (1).
  localparam logic [7:0] SEG_CODE [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // All segments and the decimal point dark.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg_hex_enc.sv
// Hex digit to 7-segment code (g..a, active-low). Purely combinational.
module seg_hex_enc
  import seg_pkg::*;
(
  input  hex_t       hex,
  output logic [6:0] code
);

  // Table lookup; the dp bit is owned by the caller.
  always_comb begin
    code = SEG_CODE[hex][6:0];
  end

endmodule

// File: rtl/seg_static_src.sv
// Static six-digit display source: every digit shows the same hex value,
// stepping 0..F (or F..0) once per prescaler tick. Feeds the 74HC595 shifter.
module seg_static_src
  import seg_pkg::*;
#(
  parameter int         CNT_MAX        = 24_999_999,
  parameter logic [5:0] SEL_ON         = 6'b111111,
  parameter int         DIR_UP_DEFAULT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       hold,
  input  logic       dir,
  input  logic       dp_on,
  output logic [3:0] digit,
  output logic [7:0] seg,
  output logic [5:0] sel,
  output logic       upd
);

  localparam int CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  // Elaboration-time sanity on parameters. DIR_UP_DEFAULT only matters in
  // builds where dir is tied off, but a bad value is still rejected here.
  if (CNT_MAX < 1) begin : g_bad_cnt
    $error("seg_static_src: CNT_MAX must be >= 1");
  end
  if (DIR_UP_DEFAULT != 0 && DIR_UP_DEFAULT != 1) begin : g_bad_dir
    $error("seg_static_src: DIR_UP_DEFAULT must be 0 or 1");
  end

  logic [CW-1:0] cnt;
  logic          tick;
  logic [6:0]    code;
  logic [7:0]    seg_nxt;

  // Tick is suppressed while frozen, so a tick lost to en falling is re-issued
  // on the first enabled cycle (cnt is still parked at CNT_MAX).
  assign tick = en && (cnt == CW'(CNT_MAX));

  // Prescaler: free-runs 0..CNT_MAX while enabled, holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

  // Digit counter: one step per tick unless held; a held tick is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit <= 4'h0;
    end else if (tick && !hold) begin
      digit <= dir ? digit + 4'h1 : digit - 4'h1;
    end
  end

  seg_hex_enc u_enc (
    .hex  (digit),
    .code (code)
  );

  assign seg_nxt = {~dp_on, code};

  // Output stage: seg trails digit by one clock; upd flags any change of seg,
  // whether from a new digit or a dp toggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_CODE[0];
      sel <= SEL_ON;
      upd <= 1'b0;
    end else begin
      seg <= seg_nxt;
      sel <= SEL_ON;
      upd <= (seg_nxt != seg);
    end
  end

endmodule

// File: tb/tb_seg_static_src.sv
// Bench for seg_static_src: behavioural model plus directed and random stimulus.
module tb_seg_static_src;

  localparam int CNT_MAX = 3;

  logic       clk, rst, en, hold, dir, dp_on;
  logic [3:0] digit;
  logic [7:0] seg;
  logic [5:0] sel;
  logic       upd;

  int tests = 0;
  int fails = 0;

  logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_static_src #(.CNT_MAX(CNT_MAX), .SEL_ON(6'b111111), .DIR_UP_DEFAULT(1)) dut (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .dir(dir), .dp_on(dp_on),
    .digit(digit), .seg(seg), .sel(sel), .upd(upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: enabled-cycle count modulo the tick period, a hex value stepped by
  // +/-1 mod 16 per unheld tick, and the displayed pattern one clock behind.
  int         m_cnt;
  logic [3:0] m_digit;
  logic [7:0] m_seg;
  logic       m_upd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt   <= 0;
      m_digit <= 4'h0;
      m_seg   <= 8'hC0;
      m_upd   <= 1'b0;
    end else begin
      if (en) m_cnt <= (m_cnt + 1) % (CNT_MAX + 1);
      if (en && m_cnt == CNT_MAX && !hold)
        m_digit <= 4'((int'(m_digit) + (dir ? 1 : 15)) % 16);
      m_seg <= {~dp_on, tbl[m_digit][6:0]};
      m_upd <= ({~dp_on, tbl[m_digit][6:0]} != m_seg);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  int upd_seen;

  // One clock: wait for the falling edge, compare all outputs against the model.
  task automatic cyc();
    @(negedge clk);
    if (rst) begin
      chk("digit", digit, m_digit);
      chk("seg",   seg,   m_seg);
      chk("sel",   sel,   6'h3F);
      chk("upd",   upd,   m_upd);
      if (upd) upd_seen++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_digit", digit, 0);
    chk("rst_seg",   seg,   8'hC0);
    chk("rst_sel",   sel,   6'h3F);
    chk("rst_upd",   upd,   0);
    rst = 1'b1;
  endtask

  initial begin
    int k;
    logic [3:0] d0;
    rst = 1'b0; en = 1'b1; hold = 1'b0; dir = 1'b1; dp_on = 1'b0;

    // Reset and first-tick latency.
    do_reset();
    repeat (3) cyc();
    chk("pre_tick_digit", digit, 0);
    cyc();
    chk("first_digit", digit, 1);
    chk("first_seg_old", seg, 8'hC0);
    cyc();
    chk("first_seg", seg, 8'hF9);
    chk("first_upd", upd, 1);

    // Up wrap: 16 ticks from 0 return to 0, one upd per tick, seg follows the table.
    do_reset();
    upd_seen = 0;
    k = 1;
    for (int i = 0; i < 16 * (CNT_MAX + 1) + 1; i++) begin
      cyc();
      if (upd) begin
        chk("upwrap_seq", seg, tbl[k % 16]);
        k++;
      end
    end
    chk("upwrap_cnt", upd_seen, 16);
    chk("upwrap_digit", digit, 0);
    chk("upwrap_seg", seg, 8'hC0);

    // Down wrap.
    dir = 1'b0;
    do_reset();
    repeat (CNT_MAX + 1) cyc();
    chk("down_digit_F", digit, 4'hF);
    cyc();
    chk("down_seg_F", seg, 8'h8E);
    repeat (CNT_MAX + 1) cyc();
    chk("down_digit_E", digit, 4'hE);
    cyc();
    chk("down_seg_E", seg, 8'h86);

    // Hold across three ticks, then release.
    dir = 1'b1;
    d0 = digit;
    hold = 1'b1;
    upd_seen = 0;
    repeat (3 * (CNT_MAX + 1)) cyc();
    chk("hold_digit", digit, d0);
    chk("hold_upd", upd_seen, 0);
    hold = 1'b0;
    repeat (CNT_MAX + 1) cyc();
    chk("hold_release", digit, 4'(d0 + 4'h1));

    // en freeze with cnt parked at 2.
    do_reset();
    repeat (2) cyc();
    en = 1'b0;
    repeat (10) cyc();
    chk("freeze_cnt", m_cnt, 2);
    chk("freeze_digit", digit, 0);
    en = 1'b1;
    cyc();
    chk("unfreeze_1", digit, 0);
    cyc();
    chk("unfreeze_2", digit, 1);

    // Decimal point on digit 5.
    k = 0;
    while (digit != 4'h5 && k < 200) begin cyc(); k++; end
    chk("dp_reach5", digit, 5);
    hold = 1'b1;
    cyc();
    chk("dp_pre", seg, 8'h92);
    dp_on = 1'b1;
    cyc();
    chk("dp_on_seg", seg, 8'h12);
    chk("dp_on_upd", upd, 1);
    dp_on = 1'b0;
    cyc();
    chk("dp_off_seg", seg, 8'h92);
    chk("dp_off_upd", upd, 1);
    hold = 1'b0;

    // Async reset mid-count with digit=9, cnt=2.
    do_reset();
    repeat (9 * (CNT_MAX + 1) + 2) cyc();
    chk("mid_digit9", digit, 9);
    chk("mid_cnt2", m_cnt, 2);
    #2 rst = 1'b0;
    #1;
    chk("async_digit", digit, 0);
    chk("async_seg", seg, 8'hC0);
    chk("async_sel", sel, 6'h3F);
    chk("async_upd", upd, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (CNT_MAX) cyc();
    chk("post_rst_pre", digit, 0);
    cyc();
    chk("post_rst_tick", digit, 1);

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      hold = ($urandom_range(0, 5) == 0);
      dir  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) dp_on = ~dp_on;
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
